// File: rtl/speed2phase_pkg.sv
// Shared widths and state encoding for speed2phase.
// The same width constants are used by the phase2speed path.
package speed2phase_pkg;

  localparam int SPEED_W = 16;
  localparam int PHASE_W = 19;
  localparam int NLOG_W  = 4;
  localparam int ACC_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Low-N-bit mask; 2^N - 1 doubles as the initial sample counter value
  function automatic logic [ACC_W-1:0] frame_mask(input logic [NLOG_W-1:0] n);
    logic [ACC_W:0] full;
    full = {{ACC_W{1'b0}}, 1'b1} << n;
    frame_mask = ACC_W'(full - {{ACC_W{1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/speed2phase_if.sv
// Speed-load / sample-strobe bus between a controller and speed2phase.
interface speed2phase_if;
  import speed2phase_pkg::*;

  logic                       speed_load;
  logic signed [SPEED_W-1:0]  in_speed;
  logic        [NLOG_W-1:0]   N;
  logic                       data_rdy;
  logic signed [PHASE_W-1:0]  out_phasediff;
  logic                       phaseen;
  logic                       frame_done;
  logic                       busy;

  modport master (
    output speed_load, in_speed, N, data_rdy,
    input  out_phasediff, phaseen, frame_done, busy
  );

  modport slave (
    input  speed_load, in_speed, N, data_rdy,
    output out_phasediff, phaseen, frame_done, busy
  );

endinterface

// File: rtl/speed2phase_frac.sv
// Residual accumulator: adds r each step modulo 2^n and flags the wrap as carry,
// so that across 2^n steps exactly r carries are produced.
module speed2phase_frac
  import speed2phase_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ACC_W-1:0]  r,
  input  logic [NLOG_W-1:0] n,
  input  logic              clear,
  input  logic              step,
  output logic              carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   modulus;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, r};
    modulus = {{ACC_W{1'b0}}, 1'b1} << n;
    carry   = (sum >= modulus);
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = carry ? ACC_W'(sum - modulus) : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/speed2phase.sv
// Spreads speed<<K over 2^N phase-difference samples (base or base+1 each)
// whose sum is exactly speed<<K; one sample per data_rdy strobe.
module speed2phase
  import speed2phase_pkg::*;
#(
  parameter int unsigned K = 3
)
(
  input  logic          clk,
  input  logic          reset,
  speed2phase_if.slave  bus
);

  state_e                    state_q, state_d;
  logic signed [PHASE_W-1:0] base_q, base_d;
  logic        [ACC_W-1:0]   r_q, r_d;
  logic        [NLOG_W-1:0]  n_q, n_d;
  logic        [ACC_W-1:0]   cnt_q, cnt_d;
  logic signed [PHASE_W-1:0] out_q, out_d;
  logic                      phaseen_q, phaseen_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;

  logic signed [PHASE_W-1:0] speed_ext;
  logic signed [PHASE_W-1:0] load_t;
  logic signed [PHASE_W-1:0] load_base;
  logic        [ACC_W-1:0]   load_r;
  logic                      frac_clear;
  logic                      frac_step;
  logic                      carry;

  // T mod 2^N in two's complement is just the low N bits of T
  always_comb begin
    speed_ext = {{(PHASE_W-SPEED_W){bus.in_speed[SPEED_W-1]}}, bus.in_speed};
    load_t    = speed_ext <<< K;
    load_base = load_t >>> bus.N;
    load_r    = load_t[ACC_W-1:0] & frame_mask(bus.N);
  end

  speed2phase_frac u_frac (
    .clk   (clk),
    .reset (reset),
    .r     (r_q),
    .n     (n_q),
    .clear (frac_clear),
    .step  (frac_step),
    .carry (carry)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    r_d        = r_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    phaseen_d  = 1'b0;
    done_d     = 1'b0;
    frac_clear = 1'b0;
    frac_step  = 1'b0;

    if (bus.speed_load) begin
      state_d    = RUN;
      base_d     = load_base;
      r_d        = load_r;
      n_d        = bus.N;
      cnt_d      = frame_mask(bus.N);
      frac_clear = 1'b1;
    end else if (state_q == RUN && bus.data_rdy) begin
      frac_step = 1'b1;
      phaseen_d = 1'b1;
      out_d     = carry ? (base_q + 19'sd1) : base_q;
      cnt_d     = cnt_q - ACC_W'(1);
      if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    // busy covers the final phaseen cycle and drops one cycle later
    busy_d = (state_d == RUN) || done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      r_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      phaseen_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      r_q       <= r_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      phaseen_q <= phaseen_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.out_phasediff = out_q;
  assign bus.phaseen       = phaseen_q;
  assign bus.frame_done    = done_q;
  assign bus.busy          = busy_q;

endmodule

// File: doc/speed2phase.md
# speed2phase

Inverse of the phase-to-speed estimator. Latches a signed speed word and, over the next 2^N sample strobes, emits one signed 19-bit phase-difference sample per strobe. The 2^N samples sum exactly to speed·2^K. It feeds the `phase2speed` input path as a closed-loop stimulus or replay source: `in_speed` drives this block, `out_phasediff`/`phaseen` drive `in_phasediff`/`data_rdy`.

## Interface
- `K`, default 3: left shift from speed to total phase per frame (16 + K ≤ 19).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `speed_load`  in  1  one-cycle strobe; latch `in_speed` and `N`, start a frame.
- `in_speed`  in  16  signed speed.
- `N`  in  4  log2 of samples per frame (0..15).
- `data_rdy`  in  1  sample-cadence strobe; each one consumes one sample while running.
- `out_phasediff`  out  19  signed phase-difference sample.
- `phaseen`  out  1  one-cycle valid for `out_phasediff`.
- `frame_done`  out  1  one-cycle pulse, coincident with the last `phaseen` of a frame.
- `busy`  out  1  high while a frame is in progress.

## Operation
- States:
  - IDLE → RUN on `speed_load`.
  - RUN → IDLE after the 2^N-th sample.
  - RUN → RUN (restart) on `speed_load`.
- Load, in one cycle:
  - T = sign-extended `in_speed` << K (19-bit signed).
  - base = T >>> N (arithmetic, floor).
  - r = T − base·2^N, unsigned 0..2^N−1.
  - acc = 0; sample counter = 2^N − 1; latch N.
- Each `data_rdy` in RUN:
  - If acc + r ≥ 2^N: output base+1, acc ← acc + r − 2^N.
  - Otherwise: output base, acc ← acc + r.
  - Counter decrements; at counter 0 assert `frame_done` and go to IDLE.
- Arithmetic:
  - acc and r are 16 bits unsigned; the comparison uses a 17-bit sum.
  - base+1 never overflows, because r > 0 implies N ≥ 1, so |base| ≤ 2^17.
- Guarantee: the sum of the frame's samples equals T exactly, for every N, K and sign.
- `data_rdy` in IDLE is ignored: no `phaseen`, outputs hold.
- `speed_load` and `data_rdy` in the same cycle: the load wins and the strobe is not consumed.
- `speed_load` mid-frame: the current frame is aborted with no `frame_done`, and a new frame starts from the new speed.
- `in_speed`/`N` changes outside a `speed_load` cycle have no effect.

## Timing
- Reset values:
  - `out_phasediff` = 0, `phaseen` = 0, `frame_done` = 0, `busy` = 0.
  - State IDLE; acc, counter, base and r = 0.
- `busy` rises the cycle after `speed_load` and falls the cycle after the final `phaseen`.
- `phaseen` and `out_phasediff`: registered, valid the cycle after the consuming `data_rdy`.
- `out_phasediff` holds its value between strobes.
- Back-to-back `data_rdy` on consecutive cycles is supported: one sample per cycle.
- A `speed_load` on the cycle of the final `phaseen` starts the next frame with no gap.
- Asserting `reset` mid-frame: immediate return to the reset values; the next frame needs a fresh `speed_load`.

## Structure
- Shared package holds:
  - `SPEED_W` = 16, `PHASE_W` = 19, `NLOG_W` = 4.
  - The IDLE/RUN state enum.
  - Width constants reused by `phase2speed`.
- Sub-module `speed2phase_frac`: residual accumulator with carry output. Inputs: r, N, clear, step. Output: carry.
- The top level holds the FSM, the counter, base/r computation and the output registers.

## Test plan
- Positive speed, K=3, N=8, `in_speed`=100:
  - T=800, base=3, r=32.
  - Samples 1–7 = 3, sample 8 = 4; 32 samples of 4 in total.
  - Frame sum = 800; `frame_done` with the 256th `phaseen`.
- Negative speed, K=3, N=8, `in_speed`=−100:
  - base=−4, r=224.
  - Sample 1 = −4, sample 2 = −3; sum = −800.
- Extremes, N=0:
  - `in_speed`=32767 → a single sample 262136 with `frame_done`.
  - `in_speed`=−32768 → −262144.
- Restart and collision:
  - `speed_load` with speed 50 after 10 samples of a speed-100 frame → no `frame_done`; the new frame sums to 400.
  - `speed_load` and `data_rdy` in the same cycle → no `phaseen` that cycle.
- Idle and reset:
  - `data_rdy` pulses while IDLE → no `phaseen`.
  - Async `reset` mid-frame → all outputs 0 within the same cycle; `busy` low.
- Cadence: `data_rdy` every 20 cycles (as driven by the `phase2speed` bench) and back-to-back every cycle → identical sample sequences.
